// File: rtl/management_rx_fifo_pkg.sv
// Shared register ids, read-FSM states and frame limits for the management RX buffer.
package management_rx_fifo_pkg;

  localparam int MAX_FRAME_LEN = 1536;
  localparam int LEN_W         = 11;

  typedef enum logic [2:0] {
    REG_STAT,
    REG_LEN,
    REG_POP,
    REG_DROPS,
    REG_RX_BUF
  } regid_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_FETCH_LO,
    RD_FETCH_HI,
    RD_DONE
  } rxread_state_t;

  function automatic regid_t decode_reg(input logic [7:0] addr);
    regid_t id;
    if (addr >= 8'h10) begin
      id = REG_RX_BUF;
    end else begin
      case (addr >> 2)
        8'd0:    id = REG_STAT;
        8'd1:    id = REG_LEN;
        8'd2:    id = REG_POP;
        default: id = REG_DROPS;
      endcase
    end
    return id;
  endfunction

endpackage

// File: rtl/management_rx_len_fifo.sv
// Committed-frame length queue: show-ahead head entry, push and pop allowed in the same cycle.
module management_rx_len_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 11
) (
  input  logic             pclk,
  input  logic             preset_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge pclk) begin
    if (!preset_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/management_rx_fifo.sv
// Management-port RX frame buffer: stores whole good frames, rolls back bad ones, APB read-out.
//   state       | meaning
//   RD_IDLE     | no RX_BUF fetch; register accesses answered with zero wait
//   RD_FETCH_LO | RAM returns byte at rd_ptr, rd_ptr+1 being addressed
//   RD_FETCH_HI | RAM returns byte at rd_ptr+1
//   RD_DONE     | word complete, pready high, pointers advance
module management_rx_fifo
  import management_rx_fifo_pkg::*;
#(
  parameter int DEPTH     = 4096,
  parameter int HDR_DEPTH = 32,
  parameter int MAX_LEN   = MAX_FRAME_LEN
) (
  input  logic        pclk,
  input  logic        preset_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [7:0]  paddr,
  input  logic [15:0] pwdata,
  output logic        pready,
  output logic [15:0] prdata,
  output logic        pslverr,
  input  logic        link_up,
  input  logic        rx_start,
  input  logic        rx_data_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_commit,
  input  logic        rx_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [7:0]       mem [DEPTH];
  logic [7:0]       ram_q;
  logic [AW-1:0]    ram_raddr;
  logic             ram_we;

  logic [PW-1:0]    wr_ptr, wr_base, rd_ptr, wr_cur;
  logic [LEN_W-1:0] wr_len, len_cur, rd_cnt, head_len, remaining;
  logic             bad, bad_cur, in_frame, space_ok;
  logic             byte_in, byte_ok, frame_end, commit_ok, drop_evt;
  logic [15:0]      drops;

  logic             hdr_full, hdr_empty, hdr_push, hdr_pop;

  rxread_state_t    state, state_nxt;
  logic             fetch_err;
  logic [7:0]       lo_q, hi_q;
  logic             access;
  regid_t           reg_id;
  logic             advance, pop_cmd, drops_clr, last_word;
  logic [1:0]       step;
  logic             unused_apb;

  assign unused_apb = ^pwdata;

  // rx_start restarts at wr_base in the same cycle, so its first byte lands at the frame start.
  always_comb begin
    wr_cur    = rx_start ? wr_base : wr_ptr;
    len_cur   = rx_start ? '0 : wr_len;
    bad_cur   = rx_start ? 1'b0 : bad;
    space_ok  = (wr_cur - rd_ptr) < PW'(DEPTH);
    frame_end = in_frame && !rx_start && (rx_commit || rx_drop);
    byte_in   = (rx_start || in_frame) && rx_data_valid && !frame_end;
    byte_ok   = byte_in && !bad_cur && space_ok && (len_cur < LEN_W'(MAX_LEN));
    commit_ok = frame_end && rx_commit && !rx_drop && !bad && (wr_len != '0) && !hdr_full;
    drop_evt  = link_up && ((frame_end && !commit_ok) || (rx_start && in_frame));
  end

  assign ram_we   = link_up && byte_ok;
  assign hdr_push = link_up && commit_ok;

  always_ff @(posedge pclk) begin
    if (!preset_n || !link_up) begin
      wr_ptr   <= '0;
      wr_base  <= '0;
      wr_len   <= '0;
      bad      <= 1'b0;
      in_frame <= 1'b0;
    end else begin
      if (rx_start)       in_frame <= 1'b1;
      else if (frame_end) in_frame <= 1'b0;
      if (frame_end) begin
        if (commit_ok) wr_base <= wr_ptr;
        else           wr_ptr  <= wr_base;
      end else if (rx_start || in_frame) begin
        wr_ptr <= wr_cur + PW'(byte_ok);
        wr_len <= len_cur + LEN_W'(byte_ok);
        bad    <= bad_cur || (byte_in && !byte_ok);
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (!preset_n)                               drops <= '0;
    else if (drops_clr)                          drops <= '0;
    else if (drop_evt && (drops != 16'hFFFF))    drops <= drops + 16'd1;
  end

  always_ff @(posedge pclk) begin
    if (ram_we) mem[wr_cur[AW-1:0]] <= rx_data;
    ram_q <= mem[ram_raddr];
  end

  management_rx_len_fifo #(
    .DEPTH (HDR_DEPTH),
    .WIDTH (LEN_W)
  ) u_len_fifo (
    .pclk     (pclk),
    .preset_n (preset_n),
    .clr      (!link_up),
    .push     (hdr_push),
    .pop      (hdr_pop),
    .din      (wr_len),
    .dout     (head_len),
    .full     (hdr_full),
    .empty    (hdr_empty)
  );

  assign access    = psel && penable;
  assign reg_id    = decode_reg(paddr);
  assign remaining = head_len - rd_cnt;
  assign last_word = remaining <= LEN_W'(2);
  assign step      = (remaining == LEN_W'(1)) ? 2'd1 : 2'd2;
  assign hdr_pop   = link_up && ((advance && last_word) || pop_cmd);

  always_comb begin
    state_nxt = state;
    pready    = 1'b0;
    prdata    = '0;
    pslverr   = 1'b0;
    ram_raddr = rd_ptr[AW-1:0];
    advance   = 1'b0;
    pop_cmd   = 1'b0;
    drops_clr = 1'b0;
    case (state)
      RD_IDLE: begin
        if (access) begin
          if (reg_id == REG_RX_BUF && !pwrite && link_up && !hdr_empty) begin
            state_nxt = RD_FETCH_LO;
          end else begin
            pready = 1'b1;
            case (reg_id)
              REG_STAT:  if (pwrite) pslverr = 1'b1;
                         else prdata = {14'b0, !hdr_empty, link_up};
              REG_LEN:   if (pwrite) pslverr = 1'b1;
                         else prdata = hdr_empty ? 16'h0 : 16'(head_len);
              REG_POP:   if (!pwrite) pslverr = 1'b1;
                         else pop_cmd = link_up && !hdr_empty;
              REG_DROPS: if (pwrite) drops_clr = 1'b1;
                         else prdata = drops;
              // RX_BUF write, or RX_BUF read with no frame to return
              default:   pslverr = 1'b1;
            endcase
          end
        end
      end
      RD_FETCH_LO: begin
        ram_raddr = rd_ptr[AW-1:0] + AW'(1);
        state_nxt = access ? RD_FETCH_HI : RD_IDLE;
      end
      RD_FETCH_HI: state_nxt = access ? RD_DONE : RD_IDLE;
      RD_DONE: begin
        pready    = 1'b1;
        state_nxt = RD_IDLE;
        if (fetch_err || !link_up) begin
          pslverr = 1'b1;
        end else begin
          prdata  = {(step == 2'd2) ? hi_q : 8'h00, lo_q};
          advance = 1'b1;
        end
      end
      default: state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state     <= RD_IDLE;
      fetch_err <= 1'b0;
      lo_q      <= '0;
      hi_q      <= '0;
      rd_ptr    <= '0;
      rd_cnt    <= '0;
    end else begin
      state <= state_nxt;
      // A link drop mid-fetch is remembered so the access still ends, but with an error.
      if (state_nxt == RD_IDLE) fetch_err <= 1'b0;
      else if (!link_up)        fetch_err <= 1'b1;
      if (state == RD_FETCH_LO) lo_q <= ram_q;
      if (state == RD_FETCH_HI) hi_q <= ram_q;
      if (!link_up) begin
        rd_ptr <= '0;
        rd_cnt <= '0;
      end else if (advance) begin
        rd_ptr <= rd_ptr + PW'(step);
        rd_cnt <= last_word ? '0 : rd_cnt + LEN_W'(step);
      end else if (pop_cmd) begin
        rd_ptr <= rd_ptr + PW'(remaining);
        rd_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_management_rx_fifo.sv
// Scoreboard bench for management_rx_fifo: APB accesses queue their expected response,
// an independent monitor compares each completed transfer.
module tb_management_rx_fifo;

  logic        pclk = 1'b0;
  logic        preset_n;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [15:0] pwdata;
  logic        pready;
  logic [15:0] prdata;
  logic        pslverr;
  logic        link_up, rx_start, rx_data_valid, rx_commit, rx_drop;
  logic [7:0]  rx_data;

  always #5 pclk = ~pclk;

  management_rx_fifo dut (
    .pclk          (pclk),
    .preset_n      (preset_n),
    .psel          (psel),
    .penable       (penable),
    .pwrite        (pwrite),
    .paddr         (paddr),
    .pwdata        (pwdata),
    .pready        (pready),
    .prdata        (prdata),
    .pslverr       (pslverr),
    .link_up       (link_up),
    .rx_start      (rx_start),
    .rx_data_valid (rx_data_valid),
    .rx_data       (rx_data),
    .rx_commit     (rx_commit),
    .rx_drop       (rx_drop)
  );

  typedef struct packed {
    logic [15:0] data;
    logic        err;
    logic [7:0]  cyc;
    logic        chk;
  } exp_t;

  exp_t  sb_q[$];
  string nm_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    acc_cyc  = 0;
  exp_t  mon_e;
  string mon_nm;
  bit    mon_ok;

  function automatic void check(input bit ok, input string nm, input string detail);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", nm, detail);
  endfunction

  function automatic logic [7:0] pb(input logic [7:0] base, input logic [7:0] step, input int i);
    return 8'(int'(base) + int'(step) * i);
  endfunction

  // Monitor: one comparison per completed APB transfer.
  initial begin
    forever begin
      @(negedge pclk);
      if (psel && penable) begin
        acc_cyc++;
        if (pready) begin
          if (sb_q.size() == 0) begin
            check(1'b0, "unexpected_response", $sformatf("got prdata=%h pslverr=%b, want none", prdata, pslverr));
          end else begin
            mon_e  = sb_q.pop_front();
            mon_nm = nm_q.pop_front();
            mon_ok = (pslverr === mon_e.err) && (!mon_e.chk || prdata === mon_e.data) &&
                     (mon_e.cyc == 8'd0 || acc_cyc == int'(mon_e.cyc));
            check(mon_ok, mon_nm,
                  $sformatf("got prdata=%h pslverr=%b cycles=%0d, want prdata=%h pslverr=%b cycles=%0d",
                            prdata, pslverr, acc_cyc, mon_e.data, mon_e.err, mon_e.cyc));
          end
          acc_cyc = 0;
        end
      end
    end
  end

  task automatic apb_xfer(input logic wr, input logic [7:0] a, input logic [15:0] wd,
                          input logic [15:0] ed, input logic ee, input int ec, input bit chk,
                          input string nm);
    exp_t e;
    int   waits;
    e.data = ed;
    e.err  = ee;
    e.cyc  = 8'(ec);
    e.chk  = chk;
    sb_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(posedge pclk); #1;
    penable = 1'b1;
    waits = 0;
    do begin
      @(negedge pclk);
      waits++;
    end while (!pready && waits < 20);
    if (!pready) begin
      check(1'b0, nm, "timeout: pready never seen, want pready within 20 cycles");
      sb_q.delete(sb_q.size() - 1);
      nm_q.delete(nm_q.size() - 1);
      acc_cyc = 0;
    end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [15:0] ed, input string nm);
    apb_xfer(1'b0, a, 16'h0, ed, 1'b0, 1, 1'b1, nm);
  endtask

  task automatic rd_err(input logic [7:0] a, input string nm);
    apb_xfer(1'b0, a, 16'h0, 16'h0, 1'b1, 1, 1'b1, nm);
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic ee, input string nm);
    apb_xfer(1'b1, a, d, 16'h0, ee, 1, 1'b0, nm);
  endtask

  task automatic send_frame(input int n, input logic [7:0] base, input logic [7:0] step, input bit good);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk); #1;
      rx_start = (i == 0); rx_data_valid = 1'b1; rx_data = pb(base, step, i);
    end
    @(posedge pclk); #1;
    rx_start = 1'b0; rx_data_valid = 1'b0; rx_commit = good; rx_drop = !good;
    @(posedge pclk); #1;
    rx_commit = 1'b0; rx_drop = 1'b0;
  endtask

  task automatic read_frame(input int n, input logic [7:0] base, input logic [7:0] step, input string nm);
    logic [7:0] lo, hi;
    for (int k = 0; k < (n + 1) / 2; k++) begin
      lo = pb(base, step, 2 * k);
      hi = (2 * k + 1 < n) ? pb(base, step, 2 * k + 1) : 8'h00;
      apb_xfer(1'b0, 8'h10, 16'h0, {hi, lo}, 1'b0, 4, 1'b1, $sformatf("%s[%0d]", nm, k));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want bench to finish");
    $fatal(1);
  end

  initial begin
    preset_n = 1'b0; link_up = 1'b1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 8'h0; pwdata = 16'h0;
    rx_start = 1'b0; rx_data_valid = 1'b0; rx_data = 8'h0; rx_commit = 1'b0; rx_drop = 1'b0;
    repeat (4) @(posedge pclk);
    @(negedge pclk);
    check(pready === 1'b0 && prdata === 16'h0 && pslverr === 1'b0, "reset_outputs",
          $sformatf("got pready=%b prdata=%h pslverr=%b, want 0/0000/0", pready, prdata, pslverr));
    @(posedge pclk); #1;
    preset_n = 1'b1;

    rd(8'h00, 16'h0001, "reset_stat");
    rd(8'h04, 16'h0000, "reset_len");
    rd(8'h0C, 16'h0000, "reset_drops");

    // 1: 64-byte ramp
    send_frame(64, 8'h00, 8'h01, 1'b1);
    rd(8'h00, 16'h0003, "t1_stat");
    rd(8'h04, 16'd64, "t1_len");
    read_frame(64, 8'h00, 8'h01, "t1_buf");
    rd(8'h00, 16'h0001, "t1_stat_after");

    // 2: odd-length frame and exhausted read
    send_frame(5, 8'hAA, 8'h11, 1'b1);
    read_frame(5, 8'hAA, 8'h11, "t2_buf");
    rd_err(8'h10, "t2_empty_read");
    rd_err(8'h08, "pop_read_err");
    wr(8'h00, 16'h1234, 1'b1, "stat_write_err");
    wr(8'h04, 16'h1234, 1'b1, "len_write_err");

    // 3: dropped frame followed by a good one
    send_frame(20, 8'hF0, 8'h01, 1'b0);
    send_frame(10, 8'h40, 8'h03, 1'b1);
    rd(8'h0C, 16'd1, "t3_drops");
    rd(8'h04, 16'd10, "t3_len");
    read_frame(10, 8'h40, 8'h03, "t3_buf");

    // 4: oversize frame
    send_frame(1600, 8'h10, 8'h01, 1'b1);
    rd(8'h0C, 16'd2, "t4_drops");
    rd(8'h04, 16'd0, "t4_len");
    send_frame(60, 8'h80, 8'h01, 1'b1);
    rd(8'h04, 16'd60, "t4_len_next");
    read_frame(60, 8'h80, 8'h01, "t4_buf");

    // 5: buffer full, POP, wrap
    send_frame(1500, 8'h00, 8'h01, 1'b1);
    send_frame(1500, 8'h11, 8'h03, 1'b1);
    send_frame(1500, 8'h55, 8'h07, 1'b1);
    rd(8'h0C, 16'd3, "t5_drops");
    rd(8'h04, 16'd1500, "t5_len_a");
    wr(8'h08, 16'h0, 1'b0, "t5_pop");
    rd(8'h04, 16'd1500, "t5_len_b");
    send_frame(1500, 8'h22, 8'h05, 1'b1);
    read_frame(1500, 8'h11, 8'h03, "t5_buf_b");
    rd(8'h04, 16'd1500, "t5_len_d");
    read_frame(1500, 8'h22, 8'h05, "t5_buf_d");
    rd(8'h00, 16'h0001, "t5_stat");
    wr(8'h08, 16'h0, 1'b0, "pop_empty_noop");
    rd(8'h0C, 16'd3, "t5_drops_after");

    // 6: link drop during a fetch with three frames queued
    send_frame(8, 8'h01, 8'h01, 1'b1);
    send_frame(8, 8'h02, 8'h01, 1'b1);
    send_frame(8, 8'h03, 8'h01, 1'b1);
    rd(8'h00, 16'h0003, "t6_stat_before");
    fork
      apb_xfer(1'b0, 8'h10, 16'h0, 16'h0, 1'b1, 0, 1'b1, "t6_linkdown_fetch");
      begin
        repeat (3) @(posedge pclk);
        #1 link_up = 1'b0;
      end
    join
    rd(8'h00, 16'h0000, "t6_stat");
    rd(8'h04, 16'h0000, "t6_len");
    rd(8'h0C, 16'd3, "t6_drops");
    @(posedge pclk); #1;
    link_up = 1'b1;
    send_frame(4, 8'h60, 8'h01, 1'b1);
    rd(8'h04, 16'd4, "t6_len_relink");
    read_frame(4, 8'h60, 8'h01, "t6_buf");
    wr(8'h0C, 16'h0, 1'b0, "drops_clear");
    rd(8'h0C, 16'd0, "drops_cleared");

    repeat (5) @(posedge pclk);
    check(sb_q.size() == 0, "scoreboard_drained",
          $sformatf("got %0d pending responses, want 0", sb_q.size()));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
